// File: rtl/pix_stager_pkg.sv
// Shared types and constants for the pixel_stager line-buffer writer.
package pix_stager_pkg;

  localparam int unsigned PIX_W     = 16;
  localparam int unsigned HALF_PIX  = 40;
  localparam int unsigned LINE_PIX  = 1024;
  localparam int unsigned STORE_PIX = 2 * HALF_PIX;
  localparam int unsigned STORE_W   = STORE_PIX * PIX_W;

  // need_pixel request encodings from scanout
  localparam logic [1:0] NEED_HI = 2'd1;
  localparam logic [1:0] NEED_LO = 2'd2;

  // Write-index landmarks
  localparam logic [6:0] IDX_TOP    = 7'(STORE_PIX - 1);
  localparam logic [6:0] IDX_MID    = 7'(HALF_PIX);
  localparam logic [6:0] IDX_LO_TOP = 7'(HALF_PIX - 1);

  localparam logic [10:0] COUN_LAST = 11'(LINE_PIX - 1);

  typedef enum logic [2:0] {
    ST_PRIME,
    ST_IDLE,
    ST_FILL_HI,
    ST_FILL_LO,
    ST_ZREQ
  } stager_state_t;

  // Column counter advance with wrap at end of the visible line
  function automatic logic [10:0] coun_next(input logic [10:0] c);
    return (c == COUN_LAST) ? '0 : c + 11'd1;
  endfunction

endpackage

// File: rtl/pixel_stager.sv
// pixel_stager: packs a valid/ready pixel stream into the 80-pixel
// double-half storage buffer read by VGA scanout, refilling each half on
// need_pixel requests and driving the zoom flush handshake.
// Optional: define PIX_STAGER_UNDERRUN_EN to add a sticky underrun output.
module pixel_stager
  import pix_stager_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_valid,
  input  logic [PIX_W-1:0]   pix_data,
  output logic               pix_ready,
  input  logic               zoom_req,
  output logic               zoom_busy,
  output logic               start,
  output logic               zoom,
  input  logic               zoom_ack2,
  input  logic [1:0]         need_pixel,
  output logic [STORE_W-1:0] storage,
  output logic [10:0]        store_coun
`ifdef PIX_STAGER_UNDERRUN_EN
  ,
  output logic               underrun
`endif
);

  stager_state_t state_q, state_d;

  logic [6:0]         wr_idx_q, wr_idx_d;
  logic [10:0]        coun_q, coun_d;
  logic [STORE_W-1:0] storage_q, storage_d;
  logic               start_q, start_d;
  logic               zoom_q, zoom_d;
  logic               busy_q, busy_d;
  logic               pend_hi_q, pend_hi_d;
  logic               pend_lo_q, pend_lo_d;

  logic        accept;
  logic        zoom_go;
  logic        zoom_done;
  logic        prime_done;
  logic        latch_en;
  logic        hi_req;
  logic        lo_req;
  logic [10:0] wr_bit;

  assign accept     = pix_valid & pix_ready;
  assign zoom_go    = zoom_req & (state_q != ST_ZREQ);
  assign zoom_done  = (state_q == ST_ZREQ) & zoom_ack2;
  assign prime_done = (state_q == ST_PRIME) & accept & (wr_idx_q == '0) & ~zoom_go;
  assign latch_en   = (state_q != ST_ZREQ) & (state_q != ST_PRIME);
  assign hi_req     = (need_pixel == NEED_HI);
  assign lo_req     = (need_pixel == NEED_LO);
  assign wr_bit     = 11'(wr_idx_q) * 11'(PIX_W);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_PRIME;
    else     state_q <= state_d;
  end

  // Next-state logic; zoom request overrides every non-ZREQ state
  always_comb begin
    state_d = state_q;
    if (zoom_go) begin
      state_d = ST_ZREQ;
    end else begin
      unique case (state_q)
        ST_PRIME:   if (accept && wr_idx_q == '0)     state_d = ST_IDLE;
        ST_IDLE: begin
          if (pend_hi_q)      state_d = ST_FILL_HI;
          else if (pend_lo_q) state_d = ST_FILL_LO;
        end
        ST_FILL_HI: if (accept && wr_idx_q == IDX_MID) state_d = ST_IDLE;
        ST_FILL_LO: if (accept && wr_idx_q == '0)      state_d = ST_IDLE;
        ST_ZREQ:    if (zoom_ack2)                     state_d = ST_PRIME;
        default:                                       state_d = ST_PRIME;
      endcase
    end
  end

  // Output logic: ready whenever the state is writing storage
  always_comb begin
    pix_ready = (state_q == ST_PRIME) || (state_q == ST_FILL_HI) ||
                (state_q == ST_FILL_LO);
  end

  // Datapath next-state: storage writes, index/column counters, flags
  always_comb begin
    storage_d = storage_q;
    wr_idx_d  = wr_idx_q;
    coun_d    = coun_q;
    start_d   = start_q;
    zoom_d    = zoom_q;
    busy_d    = busy_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;

    if (accept) begin
      if (wr_idx_q <= IDX_TOP) storage_d[wr_bit +: PIX_W] = pix_data;
      wr_idx_d = wr_idx_q - 7'd1;
      coun_d   = coun_next(coun_q);
    end

    // Serving a pending request: hi has priority over lo
    if (state_q == ST_IDLE) begin
      if (pend_hi_q) begin
        wr_idx_d  = IDX_TOP;
        pend_hi_d = 1'b0;
      end else if (pend_lo_q) begin
        wr_idx_d  = IDX_LO_TOP;
        pend_lo_d = 1'b0;
      end
    end

    // A new request sets after any clear, so a request for the half being
    // filled re-latches and triggers another fill of that half afterwards
    if (latch_en && hi_req) pend_hi_d = 1'b1;
    if (latch_en && lo_req) pend_lo_d = 1'b1;

    if (prime_done) begin
      start_d = 1'b1;
      busy_d  = 1'b0;
    end

    if (zoom_go) begin
      pend_hi_d = 1'b0;
      pend_lo_d = 1'b0;
      zoom_d    = 1'b1;
      busy_d    = 1'b1;
    end else if (zoom_done) begin
      zoom_d   = 1'b0;
      wr_idx_d = IDX_TOP;
      coun_d   = '0;
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      storage_q <= '0;
      wr_idx_q  <= IDX_TOP;
      coun_q    <= '0;
      start_q   <= 1'b0;
      zoom_q    <= 1'b0;
      busy_q    <= 1'b0;
      pend_hi_q <= 1'b0;
      pend_lo_q <= 1'b0;
    end else begin
      storage_q <= storage_d;
      wr_idx_q  <= wr_idx_d;
      coun_q    <= coun_d;
      start_q   <= start_d;
      zoom_q    <= zoom_d;
      busy_q    <= busy_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign storage    = storage_q;
  assign store_coun = coun_q;
  assign start      = start_q;
  assign zoom       = zoom_q;
  assign zoom_busy  = busy_q;

`ifdef PIX_STAGER_UNDERRUN_EN
  logic underrun_q;
  logic underrun_evt;

  assign underrun_evt = ((state_q == ST_FILL_HI) & hi_req) |
                        ((state_q == ST_FILL_LO) & lo_req);

  // Sticky underrun flag, cleared by zoom acknowledge
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               underrun_q <= 1'b0;
    else if (zoom_done)    underrun_q <= 1'b0;
    else if (underrun_evt) underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`endif

endmodule

// File: tb/tb_pixel_stager.sv
// Scoreboard bench for pixel_stager: stimulus pushes expected
// (index, data, column) per pixel; a monitor pops on each accept.
module tb_pixel_stager;
  import pix_stager_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               pix_valid = 1'b0;
  logic [PIX_W-1:0]   pix_data = '0;
  logic               pix_ready;
  logic               zoom_req = 1'b0;
  logic               zoom_busy;
  logic               start;
  logic               zoom;
  logic               zoom_ack2 = 1'b0;
  logic [1:0]         need_pixel = 2'd0;
  logic [STORE_W-1:0] storage;
  logic [10:0]        store_coun;
`ifdef PIX_STAGER_UNDERRUN_EN
  logic               underrun;
`endif

  always #5 clk = ~clk;

  pixel_stager dut (
    .clk        (clk),
    .rst        (rst),
    .pix_valid  (pix_valid),
    .pix_data   (pix_data),
    .pix_ready  (pix_ready),
    .zoom_req   (zoom_req),
    .zoom_busy  (zoom_busy),
    .start      (start),
    .zoom       (zoom),
    .zoom_ack2  (zoom_ack2),
    .need_pixel (need_pixel),
    .storage    (storage),
    .store_coun (store_coun)
`ifdef PIX_STAGER_UNDERRUN_EN
    ,
    .underrun   (underrun)
`endif
  );

  typedef struct {
    int          idx;
    logic [15:0] data;
    int          coun;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;
  int exp_coun = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] pix_at(input int i);
    return storage[i*PIX_W +: PIX_W];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one pixel for one clock; expectation queued for the monitor
  task automatic send(input int idx, input logic [15:0] d);
    chk("ready_before_send", {31'd0, pix_ready}, 32'd1);
    exp_coun = (exp_coun + 1) % LINE_PIX;
    sb.push_back('{idx, d, exp_coun});
    pix_valid = 1'b1;
    pix_data  = d;
    tick();
    pix_valid = 1'b0;
  endtask

  // Request a half and wait until the fill state has been entered
  task automatic request(input logic [1:0] which);
    need_pixel = which;
    tick();
    need_pixel = 2'd0;
    chk("ready_still_idle", {31'd0, pix_ready}, 32'd0);
    tick();
    chk("ready_fill_entered", {31'd0, pix_ready}, 32'd1);
  endtask

  // Monitor: sample accepts at negedge, check storage/column one edge later
  initial begin : monitor
    exp_t cur;
    bit   have;
    have = 1'b0;
    forever begin
      @(negedge clk);
      if (have) begin
        chk($sformatf("pix[%0d]", cur.idx), {16'd0, pix_at(cur.idx)}, {16'd0, cur.data});
        chk($sformatf("coun_after_pix[%0d]", cur.idx), {21'd0, store_coun}, cur.coun);
        have = 1'b0;
      end
      if (!rst && pix_valid && pix_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_accept: got an accept expected none queued");
        end else begin
          cur  = sb.pop_front();
          have = 1'b1;
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: got no finish expected finish before 500us");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Reset values
    repeat (3) tick();
    chk("rst_storage_zero", {31'd0, storage == '0}, 32'd1);
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_zoom", {31'd0, zoom}, 32'd0);
    chk("rst_busy", {31'd0, zoom_busy}, 32'd0);
    chk("rst_coun", {21'd0, store_coun}, 32'd0);
    chk("rst_ready", {31'd0, pix_ready}, 32'd1);
`ifdef PIX_STAGER_UNDERRUN_EN
    chk("rst_underrun", {31'd0, underrun}, 32'd0);
`endif
    rst = 1'b0;

    // Prime: values 0..79 into indices 79..0
    for (int k = 0; k < 80; k++) begin
      if (k == 79) chk("start_before_last", {31'd0, start}, 32'd0);
      send(79 - k, 16'(k));
    end
    chk("start_after_prime", {31'd0, start}, 32'd1);
    chk("idle_after_prime", {31'd0, pix_ready}, 32'd0);
    chk("coun_80", {21'd0, store_coun}, 32'd80);
    chk("prime_s79", {16'd0, pix_at(79)}, 32'd0);
    chk("prime_s0", {16'd0, pix_at(0)}, 32'd79);

    // Upper-half refill with a lower-half request arriving mid-fill
    request(NEED_HI);
    for (int k = 0; k < 40; k++) begin
      if (k == 10) need_pixel = NEED_LO;
      send(79 - k, 16'hF800);
      need_pixel = 2'd0;
    end
    chk("coun_120", {21'd0, store_coun}, 32'd120);
    chk("hi_s40", {16'd0, pix_at(40)}, 32'h0000F800);
    chk("hi_s79", {16'd0, pix_at(79)}, 32'h0000F800);
    chk("lo_kept_s39", {16'd0, pix_at(39)}, 32'd40);
    chk("lo_kept_s0", {16'd0, pix_at(0)}, 32'd79);
    chk("idle_after_hi", {31'd0, pix_ready}, 32'd0);
    tick();
    chk("fill_lo_follows", {31'd0, pix_ready}, 32'd1);
`ifdef PIX_STAGER_UNDERRUN_EN
    chk("no_underrun_yet", {31'd0, underrun}, 32'd0);
`endif

    // Lower-half fill with an underrun request for the same half
    for (int k = 0; k < 40; k++) begin
      if (k == 5) need_pixel = NEED_LO;
      send(39 - k, 16'h1000 + 16'(k));
      need_pixel = 2'd0;
    end
    chk("coun_160", {21'd0, store_coun}, 32'd160);
    chk("idle_after_lo", {31'd0, pix_ready}, 32'd0);
`ifdef PIX_STAGER_UNDERRUN_EN
    chk("underrun_set", {31'd0, underrun}, 32'd1);
`endif
    tick();
    chk("second_fill_lo", {31'd0, pix_ready}, 32'd1);
    for (int k = 0; k < 40; k++) send(39 - k, 16'h2000 + 16'(k));
    chk("coun_200", {21'd0, store_coun}, 32'd200);
    chk("hi_untouched_s79", {16'd0, pix_at(79)}, 32'h0000F800);

    // Zoom during an upper-half fill
    request(NEED_HI);
    for (int k = 0; k < 10; k++) send(79 - k, 16'h3000 + 16'(k));
    zoom_req = 1'b1;
    tick();
    zoom_req = 1'b0;
    chk("zoom_set", {31'd0, zoom}, 32'd1);
    chk("busy_set", {31'd0, zoom_busy}, 32'd1);
    chk("zreq_not_ready", {31'd0, pix_ready}, 32'd0);
    tick();
    chk("zoom_second_cycle", {31'd0, zoom}, 32'd1);
    zoom_ack2 = 1'b1;
    tick();
    zoom_ack2 = 1'b0;
    chk("zoom_cleared", {31'd0, zoom}, 32'd0);
    chk("zoom_coun_zero", {21'd0, store_coun}, 32'd0);
    chk("busy_held", {31'd0, zoom_busy}, 32'd1);
    chk("reprime_ready", {31'd0, pix_ready}, 32'd1);
    chk("storage_kept", {16'd0, pix_at(70)}, 32'h00003009);
`ifdef PIX_STAGER_UNDERRUN_EN
    chk("underrun_cleared", {31'd0, underrun}, 32'd0);
`endif
    exp_coun = 0;
    for (int k = 0; k < 80; k++) begin
      if (k == 79) chk("busy_before_last", {31'd0, zoom_busy}, 32'd1);
      send(79 - k, 16'h4000 + 16'(k));
    end
    chk("busy_cleared", {31'd0, zoom_busy}, 32'd0);
    chk("start_stays", {31'd0, start}, 32'd1);
    chk("coun_80_again", {21'd0, store_coun}, 32'd80);

    // Alternate refills until the column counter wraps past 1023
    for (int f = 0; f < 24; f++) begin
      request((f % 2 == 0) ? NEED_HI : NEED_LO);
      for (int k = 0; k < 40; k++) begin
        send(((f % 2 == 0) ? 79 : 39) - k, 16'h5000 + 16'(f * 40 + k));
        if (exp_coun == 0) chk("coun_wrap", {21'd0, store_coun}, 32'd0);
      end
    end
    chk("coun_final", {21'd0, store_coun}, 32'd16);

    repeat (3) tick();
    chk("scoreboard_drained", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
